// File: rtl/preadder_sched.sv
// Round-robin scheduler that feeds two requesters into an external pre-adder with a
// configurable D/AD register depth and collects its results in accept order.
module preadder_sched #(
    parameter int DREG  = 1,
    parameter int ADREG = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        req0_valid,
    input  logic        req1_valid,
    input  logic [2:0]  req0_op,
    input  logic [2:0]  req1_op,
    input  logic [24:0] req0_a,
    input  logic [24:0] req1_a,
    input  logic [24:0] req0_d,
    input  logic [24:0] req1_d,
    output logic        req0_ready,
    output logic        req1_ready,
    output logic [24:0] pa_d,
    output logic [24:0] pa_amult_rega,
    output logic [2:0]  pa_inmode,
    output logic        pa_ced,
    output logic        pa_cead,
    output logic        pa_rstd,
    input  logic [24:0] pa_amult,
    output logic        res_valid,
    output logic        res_id,
    output logic [24:0] res_data,
    input  logic        res_ready,
    output logic        busy
);

    localparam int W = 25;

    logic         stall;
    logic         accept_ok;
    logic         grant0;
    logic         grant1;
    logic         grant;
    logic         gnt_id;
    logic         prio;
    logic [W-1:0] gnt_a;
    logic [W-1:0] gnt_d;
    logic [2:0]   gnt_op;

    // Operation presented to the AD stage (pre-adder combinational input).
    logic         ad_in_valid;
    logic         ad_in_id;
    logic [W-1:0] ad_in_a;
    logic [2:0]   ad_in_op;

    // Operation whose pre-adder result is currently visible on pa_amult.
    logic         out_valid;
    logic         out_id;

    logic         d_busy;
    logic         ad_busy;
    logic         res_valid_q;
    logic         res_id_q;
    logic [W-1:0] res_data_q;

    assign stall     = res_valid_q & ~res_ready;
    assign accept_ok = ~rst & ~flush & ~stall;

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (accept_ok) begin
            if (req0_valid && (!req1_valid || !prio)) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign grant  = grant0 | grant1;
    assign gnt_id = grant1;

    always_comb begin
        gnt_a  = '0;
        gnt_d  = '0;
        gnt_op = '0;
        if (grant0) begin
            gnt_a  = req0_a;
            gnt_d  = req0_d;
            gnt_op = req0_op;
        end else if (grant1) begin
            gnt_a  = req1_a;
            gnt_d  = req1_d;
            gnt_op = req1_op;
        end
    end

    // Pointer only moves on a grant, so a flush leaves it where it was.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= 1'b0;
        end else if (grant0) begin
            prio <= 1'b1;
        end else if (grant1) begin
            prio <= 1'b0;
        end
    end

    generate
        if (DREG != 0) begin : g_dreg
            logic         v_q;
            logic         id_q;
            logic [W-1:0] a_q;
            logic [2:0]   op_q;

            // NOTE: the discard clear sits in the same synchronous branch as reset, so
            // flushed slots return to the idle (all-zero) state exactly like reset does.
            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    v_q  <= 1'b0;
                    id_q <= 1'b0;
                    a_q  <= '0;
                    op_q <= '0;
                end else if (!stall) begin
                    v_q  <= grant;
                    id_q <= gnt_id;
                    a_q  <= gnt_a;
                    op_q <= gnt_op;
                end
            end

            assign ad_in_valid = v_q;
            assign ad_in_id    = id_q;
            assign ad_in_a     = a_q;
            assign ad_in_op    = op_q;
            assign d_busy      = v_q;
        end else begin : g_no_dreg
            assign ad_in_valid = grant;
            assign ad_in_id    = gnt_id;
            assign ad_in_a     = gnt_a;
            assign ad_in_op    = gnt_op;
            assign d_busy      = 1'b0;
        end

        if (ADREG != 0) begin : g_adreg
            logic v_q;
            logic id_q;

            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    v_q  <= 1'b0;
                    id_q <= 1'b0;
                end else if (!stall) begin
                    v_q  <= ad_in_valid;
                    id_q <= ad_in_id;
                end
            end

            assign out_valid = v_q;
            assign out_id    = id_q;
            assign ad_busy   = v_q;
        end else begin : g_no_adreg
            assign out_valid = ad_in_valid;
            assign out_id    = ad_in_id;
            assign ad_busy   = 1'b0;
        end
    endgenerate

    // A consumed or empty result slot reloads from the last stage; a stalled one holds.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            res_valid_q <= 1'b0;
            res_id_q    <= 1'b0;
            res_data_q  <= '0;
        end else if (!stall) begin
            res_valid_q <= out_valid;
            res_id_q    <= out_valid ? out_id : 1'b0;
            res_data_q  <= out_valid ? pa_amult : '0;
        end
    end

    assign req0_ready    = grant0;
    assign req1_ready    = grant1;
    assign pa_d          = gnt_d;
    assign pa_ced        = grant;
    assign pa_cead       = ad_in_valid & ~stall & ~rst;
    assign pa_rstd       = rst | flush;
    assign pa_amult_rega = rst ? '0 : ad_in_a;
    assign pa_inmode     = rst ? '0 : ad_in_op;

    // Outputs are masked during reset so they read zero from the first reset cycle.
    assign res_valid = res_valid_q & ~rst;
    assign res_id    = res_id_q & ~rst;
    assign res_data  = rst ? '0 : res_data_q;
    assign busy      = (d_busy | ad_busy | res_valid_q) & ~rst;

endmodule

// File: tb/tb_preadder_sched.sv
// Scoreboard bench for preadder_sched: one instance with D/AD registers, one fully
// combinational instance, each driving a behavioural pre-adder model.
module tb_preadder_sched;

    typedef struct {
        logic        id;
        logic [24:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    int          checks = 0;
    int          errors = 0;

    // Registered instance (DREG=ADREG=1)
    logic        flush, req0_valid, req1_valid, req0_ready, req1_ready;
    logic [2:0]  req0_op, req1_op, pa_inmode;
    logic [24:0] req0_a, req1_a, req0_d, req1_d, pa_d, pa_amult_rega, pa_amult, res_data;
    logic        pa_ced, pa_cead, pa_rstd, res_valid, res_id, res_ready, busy;

    // Combinational instance (DREG=ADREG=0)
    logic        z_flush, z_req0_valid, z_req1_valid, z_req0_ready, z_req1_ready;
    logic [2:0]  z_req0_op, z_req1_op, z_pa_inmode;
    logic [24:0] z_req0_a, z_req1_a, z_req0_d, z_req1_d, z_pa_d, z_pa_amult_rega, z_pa_amult, z_res_data;
    logic        z_pa_ced, z_pa_cead, z_pa_rstd, z_res_valid, z_res_id, z_res_ready, z_busy;

    exp_t exp_q[$];
    exp_t z_exp_q[$];

    always #5 clk = ~clk;

    preadder_sched #(.DREG(1), .ADREG(1)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_op(req0_op), .req1_op(req1_op),
        .req0_a(req0_a), .req1_a(req1_a), .req0_d(req0_d), .req1_d(req1_d),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .pa_d(pa_d), .pa_amult_rega(pa_amult_rega), .pa_inmode(pa_inmode),
        .pa_ced(pa_ced), .pa_cead(pa_cead), .pa_rstd(pa_rstd), .pa_amult(pa_amult),
        .res_valid(res_valid), .res_id(res_id), .res_data(res_data),
        .res_ready(res_ready), .busy(busy)
    );

    preadder_sched #(.DREG(0), .ADREG(0)) u_dut_comb (
        .clk(clk), .rst(rst), .flush(z_flush),
        .req0_valid(z_req0_valid), .req1_valid(z_req1_valid),
        .req0_op(z_req0_op), .req1_op(z_req1_op),
        .req0_a(z_req0_a), .req1_a(z_req1_a), .req0_d(z_req0_d), .req1_d(z_req1_d),
        .req0_ready(z_req0_ready), .req1_ready(z_req1_ready),
        .pa_d(z_pa_d), .pa_amult_rega(z_pa_amult_rega), .pa_inmode(z_pa_inmode),
        .pa_ced(z_pa_ced), .pa_cead(z_pa_cead), .pa_rstd(z_pa_rstd), .pa_amult(z_pa_amult),
        .res_valid(z_res_valid), .res_id(z_res_id), .res_data(z_res_data),
        .res_ready(z_res_ready), .busy(z_busy)
    );

    // Pre-adder: op[0] gates A to zero, op[1] enables D, op[2] selects D-A.
    function automatic logic [24:0] preadd(input logic [24:0] d, input logic [24:0] a,
                                           input logic [2:0] op);
        logic [24:0] dd;
        logic [24:0] aa;
        dd = op[1] ? d : 25'd0;
        aa = op[0] ? 25'd0 : a;
        return op[2] ? dd - aa : dd + aa;
    endfunction

    logic [24:0] m_dreg, m_adreg;
    always @(posedge clk) begin
        if (pa_rstd) begin
            m_dreg  <= '0;
            m_adreg <= '0;
        end else begin
            if (pa_ced)  m_dreg  <= pa_d;
            if (pa_cead) m_adreg <= preadd(m_dreg, pa_amult_rega, pa_inmode);
        end
    end
    assign pa_amult   = m_adreg;
    assign z_pa_amult = preadd(z_pa_d, z_pa_amult_rega, z_pa_inmode);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every result handshake.
    exp_t m_e;
    exp_t z_e;
    always @(negedge clk) begin
        if (res_valid === 1'b1 && res_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result id=%0d data=%h at %0t", res_id, res_data, $time);
            end else begin
                m_e = exp_q.pop_front();
                check("res_id", {31'd0, res_id}, {31'd0, m_e.id});
                check("res_data", {7'd0, res_data}, {7'd0, m_e.data});
            end
        end
        if (z_res_valid === 1'b1 && z_res_ready === 1'b1) begin
            if (z_exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL z_unexpected_result id=%0d data=%h at %0t", z_res_id, z_res_data, $time);
            end else begin
                z_e = z_exp_q.pop_front();
                check("z_res_id", {31'd0, z_res_id}, {31'd0, z_e.id});
                check("z_res_data", {7'd0, z_res_data}, {7'd0, z_e.data});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect0(input logic id, input logic [24:0] data);
        exp_t e;
        e.id   = id;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic expect_z(input logic id, input logic [24:0] data);
        exp_t e;
        e.id   = id;
        e.data = data;
        z_exp_q.push_back(e);
    endtask

    task automatic drive0(input logic r, input logic [2:0] op, input logic [24:0] a,
                          input logic [24:0] d);
        if (!r) begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_d = d;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_d = d;
        end
    endtask

    // Presents one operation, waits (bounded) for its READY, then withdraws it.
    task automatic issue0(input logic r, input logic [2:0] op, input logic [24:0] a,
                          input logic [24:0] d, input logic [24:0] e);
        int n;
        expect0(r, e);
        drive0(r, op, a, d);
        #1;
        n = 0;
        while (!(r ? req1_ready : req0_ready) && n < 20) begin
            tick();
            #1;
            n++;
        end
        check("issue_ready", {31'd0, (r ? req1_ready : req0_ready)}, 32'd1);
        tick();
        if (!r) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    task automatic drain0();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        check("drain_empty", exp_q.size(), 32'd0);
    endtask

    task automatic drain_z();
        int n;
        n = 0;
        while (z_exp_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        check("z_drain_empty", z_exp_q.size(), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        flush = 1'b0; req0_valid = 1'b1; req1_valid = 1'b0;
        req0_op = 3'b010; req1_op = '0; req0_a = 25'd1; req1_a = '0; req0_d = 25'd1; req1_d = '0;
        res_ready = 1'b1;
        z_flush = 1'b0; z_req0_valid = 1'b0; z_req1_valid = 1'b0;
        z_req0_op = '0; z_req1_op = '0; z_req0_a = '0; z_req1_a = '0; z_req0_d = '0; z_req1_d = '0;
        z_res_ready = 1'b1;

        // Reset state, with a request held valid throughout
        repeat (3) tick();
        #1;
        check("rst_ready0", {31'd0, req0_ready}, 32'd0);
        check("rst_ced", {31'd0, pa_ced}, 32'd0);
        check("rst_cead", {31'd0, pa_cead}, 32'd0);
        check("rst_rstd", {31'd0, pa_rstd}, 32'd1);
        check("rst_pa_d", {7'd0, pa_d}, 32'd0);
        check("rst_rega", {7'd0, pa_amult_rega}, 32'd0);
        check("rst_inmode", {29'd0, pa_inmode}, 32'd0);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("z_rst_rstd", {31'd0, z_pa_rstd}, 32'd1);
        check("z_rst_busy", {31'd0, z_busy}, 32'd0);
        tick();
        rst = 1'b0;
        req0_valid = 1'b0;

        // op 010, A=5, D=3: 8 after three cycles
        tick();
        drive0(1'b0, 3'b010, 25'd5, 25'd3);
        expect0(1'b0, 25'd8);
        #1;
        check("t_ready0", {31'd0, req0_ready}, 32'd1);
        check("t_pa_d", {7'd0, pa_d}, 32'd3);
        check("t_ced", {31'd0, pa_ced}, 32'd1);
        tick();
        req0_valid = 1'b0;
        #1;
        check("t1_rega", {7'd0, pa_amult_rega}, 32'd5);
        check("t1_inmode", {29'd0, pa_inmode}, 32'd2);
        check("t1_cead", {31'd0, pa_cead}, 32'd1);
        check("t1_pa_d_idle", {7'd0, pa_d}, 32'd0);
        check("t1_busy", {31'd0, busy}, 32'd1);
        tick();
        #1;
        check("t2_res_valid", {31'd0, res_valid}, 32'd0);
        tick();
        #1;
        check("t3_res_valid", {31'd0, res_valid}, 32'd1);
        check("t3_res_data", {7'd0, res_data}, 32'd8);
        check("t3_res_id", {31'd0, res_id}, 32'd0);

        // Subtraction wraps modulo 2^25
        issue0(1'b0, 3'b110, 25'd7, 25'd2, 25'h1FFFFFB);
        issue0(1'b1, 3'b110, 25'd1, 25'd0, 25'h1FFFFFF);
        drain0();

        // Reset mid-operation discards it and returns the pointer to requester 0
        tick();
        drive0(1'b0, 3'b010, 25'd40, 25'd40);
        tick();
        req0_valid = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;

        // Both requesters valid continuously: grants alternate 0,1,0,1...
        drive0(1'b0, 3'b010, 25'd1, 25'd10);
        drive0(1'b1, 3'b110, 25'd3, 25'd20);
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) expect0(1'b0, 25'd11);
            else            expect0(1'b1, 25'd17);
        end
        for (int k = 0; k < 6; k++) begin
            #1;
            check("rr_ready0", {31'd0, req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
            check("rr_ready1", {31'd0, req1_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain0();

        // Three in flight, consumer stalls for four cycles
        tick();
        drive0(1'b0, 3'b010, 25'd100, 25'd23); expect0(1'b0, 25'd123);
        #1; check("st_a_ready", {31'd0, req0_ready}, 32'd1);
        tick();
        drive0(1'b0, 3'b011, 25'd55, 25'd7);   expect0(1'b0, 25'd7);
        #1; check("st_b_ready", {31'd0, req0_ready}, 32'd1);
        tick();
        drive0(1'b0, 3'b001, 25'd5, 25'd6);    expect0(1'b0, 25'd0);
        #1; check("st_c_ready", {31'd0, req0_ready}, 32'd1);
        tick();
        req0_valid = 1'b0;
        res_ready = 1'b0;
        drive0(1'b1, 3'b010, 25'd2, 25'd2);    expect0(1'b1, 25'd4);
        for (int s = 0; s < 4; s++) begin
            #1;
            check("st_ready1", {31'd0, req1_ready}, 32'd0);
            check("st_ced", {31'd0, pa_ced}, 32'd0);
            check("st_cead", {31'd0, pa_cead}, 32'd0);
            check("st_res_valid", {31'd0, res_valid}, 32'd1);
            check("st_res_data", {7'd0, res_data}, 32'd123);
            check("st_rega_hold", {7'd0, pa_amult_rega}, 32'd5);
            check("st_inmode_hold", {29'd0, pa_inmode}, 32'd1);
            tick();
        end
        res_ready = 1'b1;
        #1;
        check("st_release_ready1", {31'd0, req1_ready}, 32'd1);
        tick();
        req1_valid = 1'b0;
        drain0();

        // Flush with two in flight; pointer (now at requester 1) survives it
        tick();
        drive0(1'b0, 3'b010, 25'd1, 25'd1);
        #1; check("fl_x_ready", {31'd0, req0_ready}, 32'd1);
        tick();
        drive0(1'b0, 3'b010, 25'd2, 25'd2);
        #1; check("fl_y_ready", {31'd0, req0_ready}, 32'd1);
        tick();
        flush = 1'b1;
        drive0(1'b0, 3'b011, 25'd77, 25'd9);
        drive0(1'b1, 3'b101, 25'd3, 25'd4);
        expect0(1'b1, 25'd0);
        expect0(1'b0, 25'd9);
        #1;
        check("fl_rstd", {31'd0, pa_rstd}, 32'd1);
        check("fl_ready0", {31'd0, req0_ready}, 32'd0);
        check("fl_ready1", {31'd0, req1_ready}, 32'd0);
        tick();
        flush = 1'b0;
        #1;
        check("fl_rstd_off", {31'd0, pa_rstd}, 32'd0);
        check("fl_busy", {31'd0, busy}, 32'd0);
        check("fl_ptr_ready1", {31'd0, req1_ready}, 32'd1);
        check("fl_ptr_ready0", {31'd0, req0_ready}, 32'd0);
        tick();
        req1_valid = 1'b0;
        #1;
        check("fl_next_ready0", {31'd0, req0_ready}, 32'd1);
        tick();
        req0_valid = 1'b0;
        drain0();

        // Combinational instance: one-cycle latency
        tick();
        z_req0_valid = 1'b1; z_req0_op = 3'b000; z_req0_a = 25'd4; z_req0_d = 25'd50;
        expect_z(1'b0, 25'd4);
        #1;
        check("z_ready0", {31'd0, z_req0_ready}, 32'd1);
        check("z_ced", {31'd0, z_pa_ced}, 32'd1);
        check("z_cead", {31'd0, z_pa_cead}, 32'd1);
        check("z_rega", {7'd0, z_pa_amult_rega}, 32'd4);
        tick();
        z_req0_valid = 1'b0;
        z_req1_valid = 1'b1; z_req1_op = 3'b010; z_req1_a = 25'h1FFFFFF; z_req1_d = 25'd2;
        expect_z(1'b1, 25'd1);
        #1;
        check("z_lat_valid", {31'd0, z_res_valid}, 32'd1);
        check("z_lat_data", {7'd0, z_res_data}, 32'd4);
        check("z_ready1", {31'd0, z_req1_ready}, 32'd1);
        tick();
        z_req1_valid = 1'b0;
        #1;
        check("z_wrap_data", {7'd0, z_res_data}, 32'd1);
        drain_z();

        repeat (5) tick();
        check("final_q", exp_q.size(), 32'd0);
        check("final_z_q", z_exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/preadder_sched.md
PREADDER_SCHED -- requirements
Module: preadder_sched

Interface
REQ-001 Parameter DREG, default 1, SHALL be the D-register depth of the pre-adder this block drives; legal values are 0 and 1.
REQ-002 Parameter ADREG, default 1, SHALL be the AD-register depth of the pre-adder this block drives; legal values are 0 and 1.
REQ-003 clk  in  1  sole clock; all logic SHALL be on its rising edge.
REQ-004 RST  in  1  reset, synchronous, active-high.
REQ-005 FLUSH  in  1  synchronous pipeline discard, active-high.
REQ-006 REQ0_VALID, REQ1_VALID  in  1 each  requester n presents an operation.
REQ-007 REQ0_OP, REQ1_OP  in  3 each  pre-adder opcode, same encoding as INMODE[3:1].
REQ-008 REQ0_A, REQ1_A, REQ0_D, REQ1_D  in  25 each  operands A and D.
REQ-009 REQ0_READY, REQ1_READY  out  1 each  operation accepted this cycle.
REQ-010 PA_D  out  25  to pre-adder D.
REQ-011 PA_AMULT_REGA  out  25  to pre-adder AMULT_REGA.
REQ-012 PA_INMODE  out  3  to pre-adder INMODE.
REQ-013 PA_CED, PA_CEAD, PA_RSTD  out  1 each  to pre-adder CED, CEAD and RSTD.
REQ-014 PA_AMULT  in  25  pre-adder output; the pre-adder is configured with USE_DPORT=1.
REQ-015 RES_VALID  out  1  result available.
REQ-016 RES_ID  out  1  requester that owns the result.
REQ-017 RES_DATA  out  25  result value.
REQ-018 RES_READY  in  1  result consumer accepts.
REQ-019 BUSY  out  1  any operation in flight or a result pending.

Function
REQ-020 stall SHALL equal RES_VALID and not RES_READY; an operation SHALL be accepted only when RST=0, FLUSH=0 and stall=0.
REQ-021 Arbitration SHALL be round-robin:
- if both requesters are valid, the one named by the priority pointer wins;
- after each grant the pointer SHALL point to the other requester;
- at most one READY per cycle;
- READY SHALL be asserted only with its own VALID.
REQ-022 In the accept cycle t, PA_D SHALL carry the granted D and PA_CED SHALL be 1.
REQ-023 The granted A and OP SHALL be delayed by DREG cycles, so that PA_AMULT_REGA and PA_INMODE present them at cycle t+DREG, aligned with the registered D.
REQ-024 PA_CEAD SHALL be 1 in any non-stalled cycle in which the AD stage input holds a valid operation.
REQ-025 PA_AMULT SHALL be sampled at cycle t+DREG+ADREG into RES_DATA and RES_ID; RES_VALID SHALL rise at t+DREG+ADREG+1, giving a latency of DREG+ADREG+1 cycles.
REQ-026 Per-stage valid and ID bits SHALL shift with the data; results SHALL emerge in accept order, with none lost or duplicated.
REQ-027 A result is consumed when RES_VALID and RES_READY are both 1. On that edge RES_* SHALL load the next stage result if one exists, else RES_VALID SHALL fall.
REQ-028 While stall is 1:
- PA_CED and PA_CEAD SHALL be 0;
- all delay and valid registers SHALL hold;
- PA_AMULT_REGA and PA_INMODE SHALL hold, so a combinational (ADREG=0) output stays stable;
- RES_* SHALL hold.
REQ-029 Pre-adder arithmetic is modulo 2^25; this block SHALL pass PA_AMULT unmodified and SHALL NOT check opcode values; opcodes 001 and 101 yield 0.
REQ-030 Idle stages SHALL drive PA_D, PA_AMULT_REGA and PA_INMODE to 0.
REQ-031 FLUSH=1 SHALL, for that cycle:
- assert PA_RSTD;
- clear all stage valid bits and RES_VALID;
- block new grants;
- leave the priority pointer unchanged.
Discarded operations SHALL never produce RES_VALID.
REQ-032 If FLUSH and RES_READY are both asserted, FLUSH SHALL win.
REQ-033 BUSY SHALL be the OR of all stage valid bits and RES_VALID.

Reset
REQ-034 While RST=1:
- PA_RSTD SHALL be 1;
- all valid bits, RES_VALID, RES_ID, RES_DATA, READY outputs, PA_CED, PA_CEAD, PA_D, PA_AMULT_REGA, PA_INMODE and BUSY SHALL be 0;
- the priority pointer SHALL select requester 0.
REQ-035 RST asserted mid-operation SHALL discard all in-flight operations, as FLUSH does, and SHALL take precedence over FLUSH and the handshakes.

Verification (DREG=ADREG=1 unless stated)
REQ-036 REQ0 op 010, A=5, D=3, accepted at cycle t -> RES_VALID at t+3, RES_DATA=8, RES_ID=0.
REQ-037 REQ0 op 110, A=7, D=2 -> RES_DATA=25'h1FFFFFB.
REQ-038 Both requesters valid continuously from reset -> grants 0,1,0,1,...; RES_ID sequence matches the grants.
REQ-039 Three operations in flight, RES_READY low for 4 cycles -> no READY; PA_CED=PA_CEAD=0; after release, all three results delivered in order with correct values.
REQ-040 FLUSH pulse with two operations in flight -> PA_RSTD=1 for one cycle; no RES_VALID for the flushed operations; the next operation (op 011, D=9) returns 9.
REQ-041 DREG=0, ADREG=0: op 000, A=4 -> RES_VALID one cycle after accept, RES_DATA=4.
